// File: rtl/traffic_timer_bank.sv
// Bank of three independent prescaled down-counters timing the traffic light phases.
// Each timer restarts on its reload pulse, counts whole ticks down, then freezes with a sticky done flag.
module traffic_timer_bank #(
  parameter int TICK_DIV = 50000000,
  parameter int DUR_60   = 60,
  parameter int DUR_50   = 50,
  parameter int DUR_10   = 10,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             timer_reset_60,
  input  logic             timer_reset_50,
  input  logic             timer_reset_10,
  output logic             timer_done_60,
  output logic             timer_done_50,
  output logic             timer_done_10,
  output logic [CNT_W-1:0] rem_60,
  output logic [CNT_W-1:0] rem_50,
  output logic [CNT_W-1:0] rem_10
);

  localparam int               PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  // Slot 0 is the long timer, slot 1 the mid timer, slot 2 the short timer.
  logic [2:0]            reload;
  logic [2:0]            done_w;
  logic [2:0][CNT_W-1:0] sec_w;

  assign reload = {timer_reset_10, timer_reset_50, timer_reset_60};

  for (genvar g = 0; g < 3; g++) begin : g_timer
    localparam int               DUR      = (g == 0) ? DUR_60 : (g == 1) ? DUR_50 : DUR_10;
    localparam logic [CNT_W-1:0] SEC_INIT = CNT_W'(DUR);

    logic [PRE_W-1:0] pre_q;
    logic [CNT_W-1:0] sec_q;
    logic             done_q;

    // NOTE: sequential state uses non-blocking assignments so every timer samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pre_q  <= PRE_MAX;
        sec_q  <= SEC_INIT;
        done_q <= 1'b0;
      end else if (reload[g]) begin
        pre_q  <= PRE_MAX;
        sec_q  <= SEC_INIT;
        done_q <= 1'b0;
      end else if (!done_q) begin
        // An expired timer falls through every branch and stays frozen at zero.
        if (pre_q == '0) begin
          pre_q <= PRE_MAX;
          if (sec_q == CNT_W'(1)) begin
            sec_q  <= '0;
            done_q <= 1'b1;
          end else begin
            sec_q <= sec_q - CNT_W'(1);
          end
        end else begin
          pre_q <= pre_q - PRE_W'(1);
        end
      end
    end

    assign done_w[g] = done_q;
    assign sec_w[g]  = sec_q;
  end

  assign timer_done_60 = done_w[0];
  assign timer_done_50 = done_w[1];
  assign timer_done_10 = done_w[2];
  assign rem_60        = sec_w[0];
  assign rem_50        = sec_w[1];
  assign rem_10        = sec_w[2];

endmodule

// File: doc/traffic_timer_bank.md
Name: traffic_timer_bank

Overview:
- Timing stage feeding `traffic_light_controller`.
- Consumes the controller's one-cycle `timer_reset_60/50/10` pulses and returns sticky `timer_done_60/50/10` flags.
- Three independent down-counting timers (long/mid/short phase), each with its own clock prescaler, so every duration is cycle-exact from the reset pulse.
- Also exports remaining whole seconds per timer for a countdown display.

Parameters:
- `TICK_DIV`, default 50000000: clk cycles per timer "second"; must be ≥1.
- `DUR_60`, default 60: long timer duration in ticks; must be ≥1.
- `DUR_50`, default 50: mid timer duration in ticks; must be ≥1.
- `DUR_10`, default 10: short timer duration in ticks; must be ≥1.
- `CNT_W`, default 8: width of the remaining-ticks counters and outputs; each `DUR_*` must be < 2^`CNT_W`.

Ports:
- `clk`  input  1  system clock.
- `reset_n`  input  1  asynchronous reset, active-low.
- `timer_reset_60`  input  1  restart long timer; level-sampled on each rising clk edge.
- `timer_reset_50`  input  1  restart mid timer.
- `timer_reset_10`  input  1  restart short timer.
- `timer_done_60`  output  1  long timer expired; sticky, registered.
- `timer_done_50`  output  1  mid timer expired; sticky, registered.
- `timer_done_10`  output  1  short timer expired; sticky, registered.
- `rem_60`  output  `CNT_W`  long timer remaining ticks.
- `rem_50`  output  `CNT_W`  mid timer remaining ticks.
- `rem_10`  output  `CNT_W`  short timer remaining ticks.

Behaviour:
- Reset is one clock, asynchronous and active-low.
- Three identical timer instances X ∈ {60, 50, 10}. Each holds:
  - `pre`: prescaler, width clog2(`TICK_DIV`), minimum 1.
  - `sec`: `CNT_W` bits.
  - `done`: 1 bit.
- Async reset (`reset_n`=0): every timer goes to `sec`=`DUR_X`, `pre`=`TICK_DIV`-1, `done`=0.
  - Timers are running out of reset, so the controller's initial wait on `timer_done_60` terminates without a reset pulse.
  - `rem_X`=`DUR_X` during reset.
- Per rising edge, priority order:
  - **Reload:** if `timer_reset_X`=1: `sec`<=`DUR_X`, `pre`<=`TICK_DIV`-1, `done`<=0.
  - **Hold:** else if `done`=1: hold all state; `sec` stays 0.
  - **Tick:** else if `pre`=0: `pre`<=`TICK_DIV`-1. If `sec`=1 then `sec`<=0 and `done`<=1; otherwise `sec`<=`sec`-1.
  - **Count:** else `pre`<=`pre`-1.
- Latency:
  - Reset pulse sampled at edge k → `done` reads 0 from edge k onward.
  - `done` first reads 1 after edge k + `DUR_X`·`TICK_DIV`.
  - After `reset_n` deasserts, `done` first reads 1 after the (`DUR_X`·`TICK_DIV`)-th rising edge.
- The controller asserts reset in state s1 and tests `done` in s2 on the next cycle. The registered clear guarantees `done`=0 in that cycle, never a stale 1.
- `rem_X` = `sec`, registered, with no combinational path from inputs to outputs.
  - Decrements at each tick boundary.
  - Equals 0 exactly when `done`=1.
- Boundary conditions:
  - **Reset held N cycles:** reloads each cycle; countdown starts on the first edge with reset low.
  - **Reset coincident with expiry edge:** reload wins; `done` stays 0.
  - **Reset while `done`=1:** `done` clears next edge; full duration restarts.
  - **Simultaneous resets of several timers:** fully independent; no shared state between timers.
  - **`TICK_DIV`=1:** `pre` is always 0; `sec` decrements every edge; `done` `DUR_X` edges after reload.
  - **`DUR_X`=1:** `done` after exactly `TICK_DIV` edges.
  - **Async reset mid-count:** immediate return to the reset state above, regardless of clk.
- Counters never underflow or wrap. Once expired, a timer is frozen until reloaded.

Test Plan:
Overrides for all scenarios: `TICK_DIV`=4, `DUR_60`=3, `DUR_50`=2, `DUR_10`=1.
1. Release `reset_n` with no reset pulses → `timer_done_10` high after edge 4, `timer_done_50` after edge 8, `timer_done_60` after edge 12. `rem_60` steps 3→2→1→0 after edges 4/8/12. All flags stay high thereafter.
2. After all flags are done, pulse `timer_reset_10` for 1 cycle at edge k → `timer_done_10`=0 from edge k; high again after edge k+4. The other timers stay done.
3. Hold `timer_reset_50` high for 5 cycles, ending at edge k → `rem_50`=2 throughout; `timer_done_50` rises after edge k+8.
4. Pulse `timer_reset_60` at edge 11, one edge before its expiry → `timer_done_60` never rises at 12; it rises after edge 23.
5. Pulse `timer_reset_10` and `timer_reset_60` at the same edge k → `done_10` at k+4 and `done_60` at k+12, independently.
6. Drop `reset_n` asynchronously mid-count, between edges → all `done`=0 and `rem`={3,2,1} immediately, without waiting for a clk edge.
